// File: rtl/ysyx_25040101_ctrl_fsm.sv
// Multi-cycle minirv control sequencer: fetch handshake, decode, LSU sequencing, halt.
// Latency: ALU/jalr 2 cycles, store 3 + ready stall, load 4 + ready/response stall.
// Backpressure: holds the LSU request stable until lsu_req_ready_i; waits on lsu_rsp_valid_i.
module ysyx_25040101_ctrl_fsm #(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid_i,
  input  logic [31:0]     inst_i,
  output logic            inst_ready_o,
  output logic [3:0]      alu_ctrl_o,
  output logic            srcb_sel_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic            rf_wen_o,
  output logic [1:0]      rf_wsel_o,
  output logic            pc_wen_o,
  output logic            pc_sel_o,
  output logic            lsu_req_valid_o,
  input  logic            lsu_req_ready_i,
  output logic            lsu_wen_o,
  output logic [1:0]      lsu_size_o,
  input  logic            lsu_rsp_valid_i,
  output logic            halt_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {FETCH, EXEC, MEM, WAIT, HALT} state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_PASSB = 4'b0100;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_LSU = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;

  state_t          state, state_nxt;
  logic [XLEN-1:0] ir;
  logic            set_illegal;
  logic            rf_wen_raw;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_add, is_sub, is_addi, is_lui, is_jalr, is_load, is_store, is_ebreak;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_jalr   = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign is_load   = (opcode == 7'b0000011) && ((funct3 == 3'b010) || (funct3 == 3'b100));
  assign is_store  = (opcode == 7'b0100011) && ((funct3 == 3'b010) || (funct3 == 3'b000));
  assign is_ebreak = (ir[31:0] == 32'h0010_0073);

  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));

  assign rs1_addr_o = ir[19:15];
  assign rs2_addr_o = ir[24:20];
  assign rd_addr_o  = ir[11:7];

  // x0 is never written, whatever the instruction asked for.
  assign rf_wen_o = rf_wen_raw && (rd_addr_o != 5'd0);
  assign halt_o   = (state == HALT);

  // State, instruction register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      ir        <= '0;
      illegal_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && inst_valid_i) ir <= XLEN'(inst_i);
      if (set_illegal) illegal_o <= 1'b1;
    end
  end

  // Next-state and strobe decode from state, IR and LSU handshake.
  always_comb begin
    state_nxt       = state;
    set_illegal     = 1'b0;
    inst_ready_o    = 1'b0;
    alu_ctrl_o      = 4'b0000;
    srcb_sel_o      = 1'b0;
    imm_o           = '0;
    rf_wen_raw      = 1'b0;
    rf_wsel_o       = WSEL_ALU;
    pc_wen_o        = 1'b0;
    pc_sel_o        = 1'b0;
    lsu_req_valid_o = 1'b0;
    lsu_wen_o       = 1'b0;
    lsu_size_o      = 2'b00;

    case (state)
      FETCH: begin
        inst_ready_o = 1'b1;
        if (inst_valid_i) state_nxt = EXEC;
      end

      EXEC: begin
        state_nxt = FETCH;
        if (is_add || is_sub) begin
          alu_ctrl_o = is_sub ? ALU_SUB : ALU_ADD;
          rf_wen_raw = 1'b1;
          pc_wen_o   = 1'b1;
        end else if (is_addi || is_lui) begin
          alu_ctrl_o = is_lui ? ALU_PASSB : ALU_ADD;
          srcb_sel_o = 1'b1;
          imm_o      = is_lui ? imm_u : imm_i;
          rf_wen_raw = 1'b1;
          pc_wen_o   = 1'b1;
        end else if (is_jalr) begin
          alu_ctrl_o = ALU_ADD;
          srcb_sel_o = 1'b1;
          imm_o      = imm_i;
          rf_wen_raw = 1'b1;
          rf_wsel_o  = WSEL_PC4;
          pc_wen_o   = 1'b1;
          pc_sel_o   = 1'b1;
        end else if (is_load || is_store) begin
          // Address computed here; the request itself goes out from MEM.
          alu_ctrl_o = ALU_ADD;
          srcb_sel_o = 1'b1;
          imm_o      = is_store ? imm_s : imm_i;
          state_nxt  = MEM;
        end else if (is_ebreak) begin
          state_nxt = HALT;
        end else if (ILLEGAL_HALT) begin
          state_nxt   = HALT;
          set_illegal = 1'b1;
        end else begin
          pc_wen_o = 1'b1;
        end
      end

      MEM: begin
        // IR is frozen here, so every request field is stable until accepted.
        alu_ctrl_o      = ALU_ADD;
        srcb_sel_o      = 1'b1;
        imm_o           = is_store ? imm_s : imm_i;
        lsu_req_valid_o = 1'b1;
        lsu_wen_o       = is_store;
        lsu_size_o      = (funct3 == 3'b010) ? 2'b10 : 2'b00;
        if (lsu_req_ready_i) begin
          if (is_store) begin
            pc_wen_o  = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        if (lsu_rsp_valid_i) begin
          rf_wen_raw = 1'b1;
          rf_wsel_o  = WSEL_LSU;
          pc_wen_o   = 1'b1;
          state_nxt  = FETCH;
        end
      end

      HALT: state_nxt = HALT;

      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040101_ctrl_fsm.sv
// Scoreboard bench for the minirv control sequencer.
// Latency: n/a (testbench).
// Backpressure: drives LSU ready/response stalls from directed vectors.
module tb_ysyx_25040101_ctrl_fsm;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_SUB    = 32'h4020_81b3;
  localparam logic [31:0] I_LUI    = 32'h1234_5037;
  localparam logic [31:0] I_LW     = 32'h0080_a283;
  localparam logic [31:0] I_SB     = 32'h0020_81a3;
  localparam logic [31:0] I_JALR   = 32'h0002_80e7;
  localparam logic [31:0] I_ILL    = 32'hFFFF_FFFF;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [3:0]  alu;
    logic        srcb;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_wen;
    logic [1:0]  wsel;
    logic        pc_wen;
    logic        pc_sel;
    logic        lsu_v;
    logic        lsu_wen;
    logic [1:0]  size;
    logic        inst_ready;
    logic        halt;
    logic        illegal;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic        inst_ready_o;
  logic [3:0]  alu_ctrl_o;
  logic        srcb_sel_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        rf_wen_o;
  logic [1:0]  rf_wsel_o;
  logic        pc_wen_o, pc_sel_o;
  logic        lsu_req_valid_o, lsu_req_ready_i, lsu_wen_o;
  logic [1:0]  lsu_size_o;
  logic        lsu_rsp_valid_i;
  logic        halt_o, illegal_o;

  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];

  ysyx_25040101_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_ready_o(inst_ready_o),
    .alu_ctrl_o(alu_ctrl_o), .srcb_sel_o(srcb_sel_o), .imm_o(imm_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .rf_wen_o(rf_wen_o), .rf_wsel_o(rf_wsel_o), .pc_wen_o(pc_wen_o), .pc_sel_o(pc_sel_o),
    .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
    .lsu_wen_o(lsu_wen_o), .lsu_size_o(lsu_size_o), .lsu_rsp_valid_i(lsu_rsp_valid_i),
    .halt_o(halt_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s.alu = alu_ctrl_o;      s.srcb = srcb_sel_o;    s.imm = imm_o;
    s.rs1 = rs1_addr_o;      s.rs2 = rs2_addr_o;     s.rd = rd_addr_o;
    s.rf_wen = rf_wen_o;     s.wsel = rf_wsel_o;     s.pc_wen = pc_wen_o;
    s.pc_sel = pc_sel_o;     s.lsu_v = lsu_req_valid_o; s.lsu_wen = lsu_wen_o;
    s.size = lsu_size_o;     s.inst_ready = inst_ready_o;
    s.halt = halt_o;         s.illegal = illegal_o;
    return s;
  endfunction

  // All-zero outputs with register indices taken from the instruction held in IR.
  function automatic obs_t blank(input logic [31:0] ins);
    obs_t e;
    e = '0;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    return e;
  endfunction

  function automatic obs_t fetch_exp(input logic [31:0] prev);
    obs_t e;
    e = blank(prev);
    e.inst_ready = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic snap(input string name, input obs_t exp);
    @(negedge clk);
    check(name, sample(), exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in FETCH; returns in the EXEC cycle with valid dropped.
  task automatic issue(input string name, input logic [31:0] prev, input logic [31:0] ins);
    inst_valid_i = 1'b1;
    inst_i       = ins;
    snap({name, "_ready"}, fetch_exp(prev));
    step();
    inst_valid_i = 1'b0;
  endtask

  // Monitor: every cycle that carries a strobe or LSU request consumes one expectation.
  initial begin
    obs_t act;
    obs_t e;
    forever begin
      @(negedge clk);
      if (mon_en && (rf_wen_o === 1'b1 || pc_wen_o === 1'b1 || lsu_req_valid_o === 1'b1)) begin
        act = sample();
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event actual=%h required=none", act);
        end else begin
          e = exp_q.pop_front();
          check("event", act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    obs_t e;
    rst_n = 1'b0; inst_valid_i = 1'b0; inst_i = '0;
    lsu_req_ready_i = 1'b0; lsu_rsp_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    snap("reset_state", fetch_exp(32'h0));
    step();

    // addi x1,x0,5
    e = blank(I_ADDI); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd5;
    e.rf_wen = 1'b1; e.pc_wen = 1'b1;
    exp_q.push_back(e);
    issue("addi", 32'h0, I_ADDI);
    step();

    // sub x3,x1,x2
    e = blank(I_SUB); e.alu = 4'b0010; e.rf_wen = 1'b1; e.pc_wen = 1'b1;
    exp_q.push_back(e);
    issue("sub", I_ADDI, I_SUB);
    step();

    // lui x0,0x12345: write to x0 suppressed, PC still advances
    e = blank(I_LUI); e.alu = 4'b0100; e.srcb = 1'b1; e.imm = 32'h1234_5000; e.pc_wen = 1'b1;
    exp_q.push_back(e);
    issue("lui", I_SUB, I_LUI);
    step();

    // lw x5,8(x1): 3 stall cycles, accept, response 2 cycles after accept
    e = blank(I_LW); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd8;
    e.lsu_v = 1'b1; e.size = 2'b10;
    repeat (4) exp_q.push_back(e);
    e = blank(I_LW); e.rf_wen = 1'b1; e.wsel = 2'b01; e.pc_wen = 1'b1;
    exp_q.push_back(e);
    issue("lw", I_LUI, I_LW);
    e = blank(I_LW); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd8;
    snap("lw_exec", e);
    step(); step(); step(); step();
    lsu_req_ready_i = 1'b1;
    step();
    lsu_req_ready_i = 1'b0;
    step();
    lsu_rsp_valid_i = 1'b1;
    step();
    lsu_rsp_valid_i = 1'b0;

    // sb x2,3(x1): one stall, then accept with PC update
    e = blank(I_SB); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd3;
    e.lsu_v = 1'b1; e.lsu_wen = 1'b1; e.size = 2'b00;
    exp_q.push_back(e);
    e.pc_wen = 1'b1;
    exp_q.push_back(e);
    issue("sb", I_LW, I_SB);
    step();
    step();
    lsu_req_ready_i = 1'b1;
    step();
    lsu_req_ready_i = 1'b0;

    // jalr x1,0(x5)
    e = blank(I_JALR); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd0;
    e.rf_wen = 1'b1; e.wsel = 2'b10; e.pc_wen = 1'b1; e.pc_sel = 1'b1;
    exp_q.push_back(e);
    issue("jalr", I_SB, I_JALR);
    step();

    // Illegal encoding: sticky HALT with illegal_o, new instructions ignored
    issue("illegal", I_JALR, I_ILL);
    step();
    inst_valid_i = 1'b1; inst_i = I_ADDI;
    e = blank(I_ILL); e.halt = 1'b1; e.illegal = 1'b1;
    for (int i = 0; i < 20; i++) begin
      snap("illegal_halt", e);
      step();
    end
    inst_valid_i = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    snap("reset_after_halt", fetch_exp(32'h0));
    step();

    // ebreak: HALT without illegal cause
    issue("ebreak", 32'h0, I_EBREAK);
    step();
    e = blank(I_EBREAK); e.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      snap("ebreak_halt", e);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Reset during MEM with ready low; a late response must be ignored
    e = blank(I_LW); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd8;
    e.lsu_v = 1'b1; e.size = 2'b10;
    exp_q.push_back(e);
    issue("lw_abort", 32'h0, I_LW);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lsu_rsp_valid_i = 1'b1;
    snap("mem_reset", fetch_exp(32'h0));
    step();
    snap("rsp_ignored", fetch_exp(32'h0));
    step();
    lsu_rsp_valid_i = 1'b0;

    // Normal operation resumes after the aborted transaction
    e = blank(I_ADDI); e.alu = 4'b0001; e.srcb = 1'b1; e.imm = 32'd5;
    e.rf_wen = 1'b1; e.pc_wen = 1'b1;
    exp_q.push_back(e);
    issue("addi_post", 32'h0, I_ADDI);
    step();
    repeat (3) step();

    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
